game_controller: RTL and testbench

Parametrised game-flow controller for the ECE-mon top level. It replaces the inline state register with a standalone block that:
- filters PS/2 break codes;
- runs the full overworld/battle state machine;
- tracks player HP, score and the current professor;
- enforces a per-question countdown driven by the VGA frame tick.

It sits between `ps2_kb` and the `Graphics`/`Text` renderers, which consume its `state`, `prof`, `hp`, `score` and `timer` outputs.

---
 rtl/game_controller_pkg.sv | 24 ++
 rtl/game_controller_kb_key_filter.sv | 56 +++++
 rtl/game_controller.sv | 157 +++++++++++++++
 tb/tb_game_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_controller_pkg.sv
// Shared encodings for the ECE-mon game controller: game states and PS/2 set-2 scan codes.
package game_controller_pkg;

    typedef enum logic [3:0] {
        ST_SPLASH   = 4'd0,
        ST_INTRO    = 4'd1,
        ST_CEL      = 4'd2,
        ST_COMP     = 4'd3,
        ST_ATTACK   = 4'd4,
        ST_QUESTION = 4'd5,
        ST_RESULT   = 4'd6,
        ST_WIN      = 4'd7,
        ST_LOSE     = 4'd8
    } state_t;

    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_KEY_A  = 8'h1C;
    localparam logic [7:0] SC_KEY_B  = 8'h32;
    localparam logic [7:0] SC_KEY_C  = 8'h21;
    localparam logic [7:0] SC_KEY_D  = 8'h23;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXTEND = 8'hE0;

endpackage

// File: rtl/game_controller_kb_key_filter.sv
// PS/2 make/break filter: drops release codes and extend prefixes, decodes ENTER and A..D.
module kb_key_filter
    import game_controller_pkg::*;
#(
    parameter int NUM_CHOICES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] kb_code,
    input  logic       kb_avail,
    output logic       key_enter,
    output logic       key_choice_valid,
    output logic [1:0] key_choice,
    output logic       break_pending
);

    logic pending_d;
    logic choice_hit;

    always_comb begin
        pending_d        = break_pending;
        key_enter        = 1'b0;
        key_choice_valid = 1'b0;
        key_choice       = 2'd0;
        choice_hit       = 1'b0;
        if (kb_avail) begin
            // The extend prefix never disturbs a pending release.
            if (kb_code == SC_EXTEND) begin
                pending_d = break_pending;
            end else if (break_pending) begin
                pending_d = 1'b0;
            end else if (kb_code == SC_BREAK) begin
                pending_d = 1'b1;
            end else begin
                case (kb_code)
                    SC_ENTER: key_enter = 1'b1;
                    SC_KEY_A: begin choice_hit = 1'b1; key_choice = 2'd0; end
                    SC_KEY_B: begin choice_hit = 1'b1; key_choice = 2'd1; end
                    SC_KEY_C: begin choice_hit = 1'b1; key_choice = 2'd2; end
                    SC_KEY_D: begin choice_hit = 1'b1; key_choice = 2'd3; end
                    default:  choice_hit = 1'b0;
                endcase
                key_choice_valid = choice_hit && (32'(key_choice) < 32'(NUM_CHOICES));
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            break_pending <= 1'b0;
        end else begin
            break_pending <= pending_d;
        end
    end

endmodule

// File: rtl/game_controller.sv
// ECE-mon game-flow controller: overworld/battle FSM with HP, score, opponent index
// and a frame-driven per-question countdown.
module game_controller
    import game_controller_pkg::*;
#(
    parameter  int NUM_PROFS      = 6,
    parameter  int NUM_CHOICES    = 4,
    parameter  int HP_MAX         = 3,
    parameter  int TIMEOUT_FRAMES = 600,
    parameter  int SCORE_W        = 8,
    localparam int PROF_W         = $clog2(NUM_PROFS),
    localparam int HP_W           = $clog2(HP_MAX + 1),
    localparam int TIMER_W        = $clog2(TIMEOUT_FRAMES + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [7:0]         kb_code,
    input  logic               kb_avail,
    input  logic               frame_tick,
    input  logic               at_prof,
    input  logic               at_comp,
    input  logic [1:0]         correct_choice,
    output logic [3:0]         state,
    output logic [PROF_W-1:0]  prof,
    output logic [HP_W-1:0]    hp,
    output logic [SCORE_W-1:0] score,
    output logic [TIMER_W-1:0] timer,
    output logic               last_correct,
    output logic               question_req
);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    function automatic logic [HP_W-1:0] floor_dec(input logic [HP_W-1:0] v);
        return (v == '0) ? v : v - HP_W'(1);
    endfunction

    logic       key_enter;
    logic       key_choice_valid;
    logic [1:0] key_choice;
    logic       break_pending;

    kb_key_filter #(
        .NUM_CHOICES (NUM_CHOICES)
    ) u_filter (
        .clock            (clock),
        .reset_n          (reset_n),
        .kb_code          (kb_code),
        .kb_avail         (kb_avail),
        .key_enter        (key_enter),
        .key_choice_valid (key_choice_valid),
        .key_choice       (key_choice),
        .break_pending    (break_pending)
    );

    state_t             state_q, state_d;
    logic [PROF_W-1:0]  prof_d;
    logic [HP_W-1:0]    hp_d;
    logic [SCORE_W-1:0] score_d;
    logic [TIMER_W-1:0] timer_d;
    logic               last_d;
    logic               qreq_d;

    assign state = state_q;

    always_comb begin
        state_d = state_q;
        prof_d  = prof;
        hp_d    = hp;
        score_d = score;
        timer_d = timer;
        last_d  = last_correct;
        qreq_d  = 1'b0;
        case (state_q)
            ST_SPLASH: if (key_enter) state_d = ST_INTRO;
            ST_INTRO:  if (key_enter) state_d = ST_CEL;
            ST_CEL: begin
                if (at_comp && key_enter) state_d = ST_COMP;
                else if (at_prof)         state_d = ST_ATTACK;
            end
            ST_COMP: if (key_enter) begin
                state_d = ST_CEL;
                hp_d    = HP_W'(HP_MAX);
            end
            ST_ATTACK: if (key_enter) begin
                state_d = ST_QUESTION;
                timer_d = TIMER_W'(TIMEOUT_FRAMES);
                qreq_d  = 1'b1;
            end
            ST_QUESTION: begin
                // A key landing on the expiring tick is judged on its merits.
                if (key_choice_valid) begin
                    state_d = ST_RESULT;
                    if (key_choice == correct_choice) begin
                        score_d = sat_inc(score);
                        last_d  = 1'b1;
                    end else begin
                        hp_d   = floor_dec(hp);
                        last_d = 1'b0;
                    end
                end else if (frame_tick) begin
                    if (timer <= TIMER_W'(1)) begin
                        state_d = ST_RESULT;
                        timer_d = '0;
                        hp_d    = floor_dec(hp);
                        last_d  = 1'b0;
                    end else begin
                        timer_d = timer - TIMER_W'(1);
                    end
                end
            end
            ST_RESULT: if (key_enter) begin
                timer_d = '0;
                if (hp == '0) begin
                    state_d = ST_LOSE;
                end else if (last_correct && (prof == PROF_W'(NUM_PROFS - 1))) begin
                    state_d = ST_WIN;
                end else if (last_correct) begin
                    state_d = ST_CEL;
                    prof_d  = prof + PROF_W'(1);
                end else begin
                    state_d = ST_CEL;
                end
            end
            ST_WIN, ST_LOSE: if (key_enter) begin
                state_d = ST_SPLASH;
                prof_d  = '0;
                hp_d    = HP_W'(HP_MAX);
                score_d = '0;
            end
            default: state_d = ST_SPLASH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SPLASH;
            prof         <= '0;
            hp           <= HP_W'(HP_MAX);
            score        <= '0;
            timer        <= '0;
            last_correct <= 1'b0;
            question_req <= 1'b0;
        end else begin
            state_q      <= state_d;
            prof         <= prof_d;
            hp           <= hp_d;
            score        <= score_d;
            timer        <= timer_d;
            last_correct <= last_d;
            question_req <= qreq_d;
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Directed scoreboard bench for game_controller: default build plus a 2-prof / 2-choice build.
module tb_game_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] kb_code = 8'h00;
    logic       kb_avail = 1'b0;
    logic       frame_tick = 1'b0;
    logic       at_prof = 1'b0;
    logic       at_comp = 1'b0;
    logic [1:0] correct_choice = 2'd0;

    logic [3:0] state1;
    logic [2:0] prof1;
    logic [1:0] hp1;
    logic [7:0] score1;
    logic [9:0] timer1;
    logic       last1, qreq1;

    logic [3:0] state2;
    logic [0:0] prof2;
    logic [1:0] hp2;
    logic [7:0] score2;
    logic [9:0] timer2;
    logic       last2, qreq2;

    always #20 clock = ~clock;

    game_controller dut (
        .clock(clock), .reset_n(reset_n), .kb_code(kb_code), .kb_avail(kb_avail),
        .frame_tick(frame_tick), .at_prof(at_prof), .at_comp(at_comp),
        .correct_choice(correct_choice), .state(state1), .prof(prof1), .hp(hp1),
        .score(score1), .timer(timer1), .last_correct(last1), .question_req(qreq1)
    );

    game_controller #(.NUM_PROFS(2), .NUM_CHOICES(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .kb_code(kb_code), .kb_avail(kb_avail),
        .frame_tick(frame_tick), .at_prof(at_prof), .at_comp(at_comp),
        .correct_choice(correct_choice), .state(state2), .prof(prof2), .hp(hp2),
        .score(score2), .timer(timer2), .last_correct(last2), .question_req(qreq2)
    );

    localparam int ST = 0, PR = 1, HP = 2, SC = 3, TM = 4, LC = 5, QR = 6, D2 = 10;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [31:0] obs(int sel);
        case (sel)
            ST:      return {28'd0, state1};
            PR:      return {29'd0, prof1};
            HP:      return {30'd0, hp1};
            SC:      return {24'd0, score1};
            TM:      return {22'd0, timer1};
            LC:      return {31'd0, last1};
            QR:      return {31'd0, qreq1};
            D2 + ST: return {28'd0, state2};
            D2 + PR: return {31'd0, prof2};
            D2 + HP: return {30'd0, hp2};
            D2 + SC: return {24'd0, score2};
            D2 + TM: return {22'd0, timer2};
            D2 + LC: return {31'd0, last2};
            D2 + QR: return {31'd0, qreq2};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input int val);
        exp_q.push_back('{tag, sel, 32'(val)});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs(e.sel);
            tests++;
            assert (o === e.val) else begin
                fails++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
            end
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic key(input logic [7:0] code);
        kb_code  = code;
        kb_avail = 1'b1;
        @(negedge clock);
        kb_avail = 1'b0;
        drain();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
        drain();
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge clock);
        frame_tick = 1'b0;
        drain();
    endtask

    task automatic to_question(input int base);
        at_prof = 1'b1;
        expect_v("cel_to_attack", base + ST, 4);
        idle(1);
        at_prof = 1'b0;
        expect_v("attack_to_question", base + ST, 5);
        expect_v("question_req_pulse", base + QR, 1);
        expect_v("timer_load", base + TM, 600);
        key(8'h5A);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        expect_v("rst_state", ST, 0);
        expect_v("rst_prof", PR, 0);
        expect_v("rst_hp", HP, 3);
        expect_v("rst_score", SC, 0);
        expect_v("rst_timer", TM, 0);
        expect_v("rst_last", LC, 0);
        expect_v("rst_qreq", QR, 0);
        drain();
        reset_n = 1'b1;
        @(negedge clock);

        expect_v("splash_enter", ST, 1);  key(8'h5A);
        expect_v("intro_enter", ST, 2);   key(8'h5A);
        expect_v("break_code", ST, 2);    key(8'hF0);
        expect_v("release_ignored", ST, 2); key(8'h5A);

        // First question answered correctly with C
        to_question(0);
        expect_v("qreq_single", QR, 0);
        expect_v("question_hold", ST, 5);
        expect_v("timer_hold", TM, 600);
        idle(1);
        correct_choice = 2'd2;
        expect_v("correct_result", ST, 6);
        expect_v("correct_score", SC, 1);
        expect_v("correct_last", LC, 1);
        expect_v("correct_hp", HP, 3);
        key(8'h21);
        expect_v("advance_state", ST, 2);
        expect_v("advance_prof", PR, 1);
        expect_v("result_timer_clear", TM, 0);
        key(8'h5A);

        // Timeout counts as wrong
        to_question(0);
        expect_v("timer_599", TM, 1);
        expect_v("before_timeout", ST, 5);
        ticks(599);
        expect_v("timeout_result", ST, 6);
        expect_v("timeout_hp", HP, 2);
        expect_v("timeout_last", LC, 0);
        expect_v("timeout_timer", TM, 0);
        expect_v("timeout_score", SC, 1);
        ticks(1);
        expect_v("retry_state", ST, 2);
        expect_v("retry_prof", PR, 1);
        key(8'h5A);

        // Key and final tick together: the key decides
        to_question(0);
        expect_v("timer_at_1", TM, 1);
        ticks(599);
        correct_choice = 2'd0;
        expect_v("race_state", ST, 6);
        expect_v("race_last", LC, 1);
        expect_v("race_score", SC, 2);
        expect_v("race_hp", HP, 2);
        expect_v("race_timer", TM, 1);
        frame_tick = 1'b1;
        key(8'h1C);
        frame_tick = 1'b0;
        expect_v("race_advance_prof", PR, 2);
        expect_v("race_timer_clear", TM, 0);
        key(8'h5A);

        // Computer terminal refills HP
        at_comp = 1'b1;
        expect_v("comp_enter", ST, 3);
        expect_v("comp_hp_before", HP, 2);
        key(8'h5A);
        at_comp = 1'b0;
        expect_v("comp_exit", ST, 2);
        expect_v("comp_hp_refill", HP, 3);
        key(8'h5A);

        // Three wrong answers drain HP to LOSE
        correct_choice = 2'd1;
        for (int i = 0; i < 3; i++) begin
            to_question(0);
            expect_v("wrong_result", ST, 6);
            expect_v("wrong_hp", HP, 2 - i);
            expect_v("wrong_last", LC, 0);
            key(8'h1C);
            if (i < 2) begin
                expect_v("wrong_retry_prof", PR, 2);
                expect_v("wrong_retry_state", ST, 2);
            end else begin
                expect_v("lose_state", ST, 8);
            end
            key(8'h5A);
        end
        expect_v("lose_to_splash", ST, 0);
        expect_v("lose_hp_reset", HP, 3);
        expect_v("lose_score_reset", SC, 0);
        expect_v("lose_prof_reset", PR, 0);
        key(8'h5A);

        // Small build: two profs, two choices
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        expect_v("d2_rst_state", D2 + ST, 0);
        expect_v("d2_rst_hp", D2 + HP, 3);
        idle(1);
        key(8'h5A);
        expect_v("d2_cel", D2 + ST, 2);
        key(8'h5A);
        for (int r = 0; r < 2; r++) begin
            to_question(D2);
            expect_v("d2_key_d_ignored", D2 + ST, 5);
            key(8'h23);
            correct_choice = 2'd1;
            expect_v("d2_correct", D2 + ST, 6);
            expect_v("d2_last", D2 + LC, 1);
            expect_v("d2_score", D2 + SC, r + 1);
            key(8'h32);
            if (r == 0) begin
                expect_v("d2_advance_prof", D2 + PR, 1);
                expect_v("d2_advance_state", D2 + ST, 2);
            end else begin
                expect_v("d2_win", D2 + ST, 7);
            end
            key(8'h5A);
        end
        expect_v("d2_win_to_splash", D2 + ST, 0);
        expect_v("d2_win_prof_reset", D2 + PR, 0);
        expect_v("d2_win_score_reset", D2 + SC, 0);
        key(8'h5A);

        // Reset mid-question with a release pending
        key(8'h5A);
        key(8'h5A);
        to_question(D2);
        expect_v("d2_pending_break", D2 + ST, 5);
        key(8'hF0);
        #2 reset_n = 1'b0;
        #1;
        expect_v("abort_state", D2 + ST, 0);
        expect_v("abort_timer", D2 + TM, 0);
        expect_v("abort_qreq", D2 + QR, 0);
        drain();
        @(negedge clock);
        reset_n = 1'b1;
        expect_v("break_cleared_by_reset", D2 + ST, 1);
        key(8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
